layer00_sched: RTL

- Sequences one full convolution layer on the layer00 datapath (parsing front-end plus 3x3 MAC), one output channel at a time.
- Per channel it:
  - fetches 9 weights and a bias from the weight buffer,
  - holds them stable on the MAC weight/bias inputs,
  - pulses the parsing start,
  - counts MAC output valids until the channel's feature map is complete.
- Sits above the layer00 top, driven by the network-level controller via a start/done handshake.

---
 rtl/layer00_sched_if.sv | 43 ++++
 rtl/layer00_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/layer00_sched_if.sv
// Scheduler-side bundle: controller handshake, weight buffer read port and MAC/parser hooks.
// master = scheduler, slave = surrounding layer00 datapath and network controller.
interface layer00_sched_if #(
  parameter int CH_W = 4
);
  logic            iLayerStart;
  logic            iAbort;
  logic            oBusy;
  logic            oDone;
  logic            oWbufRe;
  logic [CH_W-1:0] oWbufAddr;
  logic [87:0]     iWbufData;
  logic [7:0]      oWeight0;
  logic [7:0]      oWeight1;
  logic [7:0]      oWeight2;
  logic [7:0]      oWeight3;
  logic [7:0]      oWeight4;
  logic [7:0]      oWeight5;
  logic [7:0]      oWeight6;
  logic [7:0]      oWeight7;
  logic [7:0]      oWeight8;
  logic [15:0]     oBias;
  logic            oParseStart;
  logic            iMacOutVld;
  logic [CH_W-1:0] oChIdx;
  logic            oErr;

  modport master (
    input  iLayerStart, iAbort, iWbufData, iMacOutVld,
    output oBusy, oDone, oWbufRe, oWbufAddr,
           oWeight0, oWeight1, oWeight2, oWeight3, oWeight4,
           oWeight5, oWeight6, oWeight7, oWeight8, oBias,
           oParseStart, oChIdx, oErr
  );

  modport slave (
    output iLayerStart, iAbort, iWbufData, iMacOutVld,
    input  oBusy, oDone, oWbufRe, oWbufAddr,
           oWeight0, oWeight1, oWeight2, oWeight3, oWeight4,
           oWeight5, oWeight6, oWeight7, oWeight8, oBias,
           oParseStart, oChIdx, oErr
  );
endinterface

// File: rtl/layer00_sched.sv
// Per-layer scheduler: fetches weights/bias per output channel, kicks the parser, counts MAC outputs.
// Optional busy-cycle counter oCycleCnt when LAYER00_SCHED_PERF_EN is defined.
module layer00_sched #(
  parameter int NUM_OCH    = 16,
  parameter int OUT_PER_CH = 4096,
  parameter int CH_W       = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  layer00_sched_if.master bus
`ifdef LAYER00_SCHED_PERF_EN
  ,
  output logic [31:0]   oCycleCnt
`endif
);

  // state | meaning
  // IDLE  | waiting for iLayerStart       FETCH | weight buffer read   LATCH | capture weights/bias
  // START | parser start pulse           RUN   | count MAC valids     NEXT  | advance channel
  // DONE  | layer-complete pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_RUN, S_NEXT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_OUT  = CNT_W'(OUT_PER_CH);
  localparam logic [CH_W-1:0]  LP_LAST = CH_W'(NUM_OCH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [7:0]       r_wgt [9];
  logic [15:0]      r_bias;

  logic             w_start_acc;
  logic             w_abort;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last_vld;

  assign w_start_acc = (r_state == S_IDLE) && bus.iLayerStart;
  assign w_abort     = (r_state != S_IDLE) && bus.iAbort;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last_vld  = (r_state == S_RUN) && bus.iMacOutVld && (w_cnt_inc == LP_OUT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    bus.oBusy       = (r_state != S_IDLE);
    bus.oWbufRe     = 1'b0;
    bus.oParseStart = 1'b0;
    bus.oDone       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_next = S_FETCH;
      S_FETCH: begin
        bus.oWbufRe = 1'b1;
        w_next      = S_LATCH;
      end
      S_LATCH: w_next = S_START;
      S_START: begin
        bus.oParseStart = 1'b1;
        w_next          = S_RUN;
      end
      S_RUN:   if (w_last_vld) w_next = S_NEXT;
      S_NEXT:  w_next = (r_ch == LP_LAST) ? S_DONE : S_FETCH;
      S_DONE: begin
        bus.oDone = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort beats every other transition but only outside IDLE.
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch   <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_bias <= '0;
      for (int k = 0; k < 9; k++) r_wgt[k] <= '0;
    end else begin
      if (w_abort) begin
        r_ch  <= '0;
        r_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE:  if (w_start_acc) r_ch <= '0;
          S_LATCH: begin
            for (int k = 0; k < 9; k++) r_wgt[k] <= bus.iWbufData[8*k +: 8];
            r_bias <= bus.iWbufData[87:72];
          end
          S_START: r_cnt <= '0;
          S_RUN:   if (bus.iMacOutVld) r_cnt <= w_cnt_inc;
          S_NEXT:  if (r_ch != LP_LAST) r_ch <= r_ch + 1'b1;
          default: ;
        endcase
      end
      // A fresh layer wipes the error even if a stray valid arrives alongside the start.
      if (w_start_acc)                              r_err <= 1'b0;
      else if (bus.iMacOutVld && r_state != S_RUN) r_err <= 1'b1;
    end
  end

  assign bus.oWbufAddr = r_ch;
  assign bus.oChIdx    = r_ch;
  assign bus.oErr      = r_err;
  assign bus.oWeight0  = r_wgt[0];
  assign bus.oWeight1  = r_wgt[1];
  assign bus.oWeight2  = r_wgt[2];
  assign bus.oWeight3  = r_wgt[3];
  assign bus.oWeight4  = r_wgt[4];
  assign bus.oWeight5  = r_wgt[5];
  assign bus.oWeight6  = r_wgt[6];
  assign bus.oWeight7  = r_wgt[7];
  assign bus.oWeight8  = r_wgt[8];
  assign bus.oBias     = r_bias;

`ifdef LAYER00_SCHED_PERF_EN
  logic [31:0] r_cyc;

  always_ff @(posedge clk) begin
    if (rst)                                          r_cyc <= '0;
    else if (w_start_acc)                             r_cyc <= '0;
    else if (r_state != S_IDLE && r_cyc != 32'hFFFF_FFFF) r_cyc <= r_cyc + 1'b1;
  end

  assign oCycleCnt = r_cyc;
`endif

endmodule
